dual_slope_seq: RTL and testbench

- Conversion sequencer for the dual-slope analog front end (`analog_top`). It drives `afe_sel`, `afe_reset`, `ref_sign` and `range_sel` through reset → auto-zero → integrate → de-integrate.
- It counts de-integration cycles until the comparator crosses zero, then presents a signed magnitude count with a valid/ready handshake.
- It sits between the digital measurement/display logic and `analog_top`.

---
 rtl/voltmeter_pkg.sv | 42 ++++
 rtl/dual_slope_seq_sync2.sv | 26 ++
 rtl/dual_slope_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_dual_slope_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voltmeter_pkg.sv
// Shared types for the dual-slope voltmeter front-end sequencer.
// State, AFE phase and error encodings.
package voltmeter_pkg;

    // Conversion sequencer states
    typedef enum logic [2:0] {
        IDLE,
        WAIT_REF,
        AFE_RST,
        AZ,
        INT,
        DEINT,
        DONE
    } state_e;

    // AFE phase select encodings
    localparam logic [1:0] AFE_IDLE  = 2'b00;
    localparam logic [1:0] AFE_AZ    = 2'b01;
    localparam logic [1:0] AFE_INT   = 2'b10;
    localparam logic [1:0] AFE_DEINT = 2'b11;

    // Result status codes
    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_OVR = 2'b01,
        ERR_SAT = 2'b10
    } err_e;

    // Map a sequencer state onto the AFE phase it drives
    function automatic logic [1:0] afe_sel_of(input state_e s);
        logic [1:0] sel;
        sel = AFE_IDLE;
        unique case (s)
            AZ:      sel = AFE_AZ;
            INT:     sel = AFE_INT;
            DEINT:   sel = AFE_DEINT;
            default: sel = AFE_IDLE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dual_slope_seq_sync2.sv
// Two-flop synchronizer for asynchronous AFE status lines.
// Asynchronous active-high reset clears both stages.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops to resolve metastability
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/dual_slope_seq.sv
// Dual-slope conversion sequencer: reset, auto-zero, integrate,
// de-integrate, then hand a signed count over a valid/ready port.
module dual_slope_seq
    import voltmeter_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int AZ_CYCLES  = 1000,
    parameter int INT_CYCLES = 10000,
    parameter int DEINT_MAX  = 20000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic [2:0]       range_i,
    input  logic             ref_ok_i,
    input  logic             comp_i,
    input  logic             sat_hi_i,
    input  logic             sat_lo_i,
    output logic [1:0]       afe_sel_o,
    output logic             afe_reset_o,
    output logic             ref_sign_o,
    output logic [2:0]       range_sel_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] result_o,
    output logic             sign_o,
    output logic [1:0]       err_o,
    output logic             result_valid_o,
    input  logic             result_ready_i
);

    localparam logic [CNT_W-1:0] AZ_LAST  = CNT_W'(AZ_CYCLES - 1);
    localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEI_LIM  = CNT_W'(DEINT_MAX);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pol;
    logic [2:0]       r_range;
    logic [CNT_W-1:0] r_result;
    logic             r_sign;
    err_e             r_err;

    logic             w_comp_s;
    logic             w_sat_hi_s;
    logic             w_sat_lo_s;
    logic             w_ref_ok_s;
    logic             w_sat;

    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_pol_ld;
    logic             w_pol_clr;
    logic             w_res_ld;
    logic [CNT_W-1:0] w_res_val;
    err_e             w_err_val;
    logic             w_range_ld;

    sync2 u_sync_comp (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (comp_i),
        .q_o   (w_comp_s)
    );

    sync2 u_sync_sat_hi (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sat_hi_i),
        .q_o   (w_sat_hi_s)
    );

    sync2 u_sync_sat_lo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sat_lo_i),
        .q_o   (w_sat_lo_s)
    );

    sync2 u_sync_ref_ok (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ref_ok_i),
        .q_o   (w_ref_ok_s)
    );

    assign w_sat = w_sat_hi_s | w_sat_lo_s;

    // Sequencer state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, datapath strobes and AFE-facing outputs
    always_comb begin
        w_next         = r_state;
        w_cnt_clr      = 1'b0;
        w_cnt_inc      = 1'b0;
        w_pol_ld       = 1'b0;
        w_pol_clr      = 1'b0;
        w_res_ld       = 1'b0;
        w_res_val      = '0;
        w_err_val      = ERR_OK;
        w_range_ld     = 1'b0;
        afe_sel_o      = afe_sel_of(r_state);
        afe_reset_o    = (r_state == AFE_RST);
        ref_sign_o     = (r_state == DEINT) & r_pol;
        busy_o         = (r_state != IDLE);
        result_valid_o = (r_state == DONE);

        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_range_ld = 1'b1;
                    w_next     = WAIT_REF;
                end
            end
            WAIT_REF: begin
                if (w_ref_ok_s) begin
                    w_next = AFE_RST;
                end
            end
            AFE_RST: begin
                w_cnt_clr = 1'b1;
                w_pol_clr = 1'b1;
                w_next    = AZ;
            end
            AZ: begin
                if (w_sat) begin
                    w_res_ld  = 1'b1;
                    w_err_val = ERR_SAT;
                    w_next    = DONE;
                end else if (r_cnt == AZ_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_next    = INT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            INT: begin
                if (w_sat) begin
                    w_res_ld  = 1'b1;
                    w_err_val = ERR_SAT;
                    w_next    = DONE;
                end else if (r_cnt == INT_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_pol_ld  = 1'b1;
                    w_next    = DEINT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            DEINT: begin
                if (w_sat) begin
                    w_res_ld  = 1'b1;
                    w_err_val = ERR_SAT;
                    w_next    = DONE;
                end else if (w_comp_s != r_pol) begin
                    w_res_ld  = 1'b1;
                    w_res_val = r_cnt;
                    w_err_val = ERR_OK;
                    w_next    = DONE;
                end else if (r_cnt == DEI_LIM) begin
                    w_res_ld  = 1'b1;
                    w_res_val = DEI_LIM;
                    w_err_val = ERR_OVR;
                    w_next    = DONE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    if (cont_i) begin
                        w_range_ld = 1'b1;
                        w_next     = WAIT_REF;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Shared phase counter, saturating at all-ones
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Input polarity captured at the end of integration
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pol <= 1'b0;
        end else if (w_pol_clr) begin
            r_pol <= 1'b0;
        end else if (w_pol_ld) begin
            r_pol <= w_comp_s;
        end
    end

    // Range latch, updated only at conversion start or restart
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_range <= '0;
        end else if (w_range_ld) begin
            r_range <= range_i;
        end
    end

    // Result registers, held until the next conversion finishes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_result <= '0;
            r_sign   <= 1'b0;
            r_err    <= ERR_OK;
        end else if (w_res_ld) begin
            r_result <= w_res_val;
            r_sign   <= r_pol;
            r_err    <= w_err_val;
        end
    end

    assign range_sel_o = r_range;
    assign result_o    = r_result;
    assign sign_o      = r_sign;
    assign err_o       = r_err;

endmodule

// File: tb/tb_dual_slope_seq.sv
// Randomized scoreboard bench for dual_slope_seq.
// Expected results come from a count-level model of the conversion.
module tb_dual_slope_seq;

    localparam int W    = 16;
    localparam int AZ   = 4;
    localparam int INTC = 16;
    localparam int DMAX = 40;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic         cont_i;
    logic [2:0]   range_i;
    logic         ref_ok_i;
    logic         comp_i;
    logic         sat_hi_i;
    logic         sat_lo_i;
    logic [1:0]   afe_sel_o;
    logic         afe_reset_o;
    logic         ref_sign_o;
    logic [2:0]   range_sel_o;
    logic         busy_o;
    logic [W-1:0] result_o;
    logic         sign_o;
    logic [1:0]   err_o;
    logic         result_valid_o;
    logic         result_ready_i;

    dual_slope_seq #(
        .CNT_W      (W),
        .AZ_CYCLES  (AZ),
        .INT_CYCLES (INTC),
        .DEINT_MAX  (DMAX)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .cont_i         (cont_i),
        .range_i        (range_i),
        .ref_ok_i       (ref_ok_i),
        .comp_i         (comp_i),
        .sat_hi_i       (sat_hi_i),
        .sat_lo_i       (sat_lo_i),
        .afe_sel_o      (afe_sel_o),
        .afe_reset_o    (afe_reset_o),
        .ref_sign_o     (ref_sign_o),
        .range_sel_o    (range_sel_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .sign_o         (sign_o),
        .err_o          (err_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] res;
        logic         sign;
        logic [1:0]   err;
        bit           sign_care;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Count-level model: the comparator flip driven in de-integrate
    // cycle d reaches the counter two clocks later; saturation wins.
    function automatic exp_t model(input bit pol, input int d,
                                   input bit sat);
        exp_t e;
        e.sign_care = 1'b1;
        e.sign      = pol;
        if (sat) begin
            e.res       = '0;
            e.err       = 2'b10;
            e.sign_care = 1'b0;
        end else if (d >= 0 && d + 2 <= DMAX) begin
            e.res = W'(d + 2);
            e.err = 2'b00;
        end else begin
            e.res = W'(DMAX);
            e.err = 2'b01;
        end
        return e;
    endfunction

    // Monitor: compare every accepted result with the scoreboard head
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && result_valid_o && result_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("result", result_o, e.res);
                chk("err", err_o, e.err);
                if (e.sign_care) chk("sign", sign_o, e.sign);
            end
        end
    end

    task automatic conv(input bit pol, input int d, input bit sat,
                        input int soff, input bit lo,
                        input logic [2:0] rng, input bit do_start,
                        input int hold, input bit cont_mode);
        exp_t         e;
        int           i;
        int           naz;
        int           nint;
        int           ndei;
        int           badref;
        int           unstable;
        int           waited;
        logic [W-1:0] sres;
        logic [1:0]   serr;
        logic         ssign;
        e = model(pol, d, sat);
        sb_q.push_back(e);
        comp_i = pol;
        if (do_start) begin
            range_i = rng;
            start_i = 1'b1;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            waited = 0;
            while (!afe_reset_o && waited < 50) begin
                @(posedge clk_i); #1;
                waited++;
            end
            chk("afe_reset_seen", afe_reset_o, 1);
        end
        chk("range_latched", range_sel_o, rng);
        chk("afe_sel_in_rst", afe_sel_o, 0);
        range_i = 3'($urandom);
        i = 0; naz = 0; nint = 0; ndei = 0; badref = 0;
        while (i < 200) begin
            @(posedge clk_i); #1;
            if (sat && i == AZ + soff) begin
                if (lo) sat_lo_i = 1'b1;
                else    sat_hi_i = 1'b1;
            end
            if (i == AZ + soff + 3) begin
                sat_hi_i = 1'b0;
                sat_lo_i = 1'b0;
            end
            if (d >= 0 && i == AZ + INTC + d) comp_i = ~pol;
            if (result_valid_o) break;
            if (i == 0) chk("afe_reset_one_cycle", afe_reset_o, 0);
            case (afe_sel_o)
                2'b01: naz++;
                2'b10: nint++;
                2'b11: begin
                    ndei++;
                    if (ref_sign_o !== pol) badref++;
                end
                default: ;
            endcase
            i++;
        end
        chk("done_timeout", result_valid_o, 1);
        sat_hi_i = 1'b0;
        sat_lo_i = 1'b0;
        chk("az_cycles", naz, AZ);
        chk("int_cycles", nint, sat ? soff + 3 : INTC);
        chk("deint_cycles", ndei, sat ? 0 : int'(e.res) + 1);
        chk("ref_sign", badref, 0);
        chk("range_held", range_sel_o, rng);
        chk("busy_done", busy_o, 1);
        sres  = result_o;
        serr  = err_o;
        ssign = sign_o;
        if (cont_mode) begin
            ref_ok_i = 1'b0;
            range_i  = 3'b101;
        end
        unstable = 0;
        repeat (hold) begin
            @(posedge clk_i); #1;
            if (!result_valid_o || result_o !== sres ||
                err_o !== serr || sign_o !== ssign) unstable++;
        end
        chk("hold_stable", unstable, 0);
        result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
        chk("valid_drop", result_valid_o, 0);
        if (cont_mode) begin
            chk("cont_busy", busy_o, 1);
            chk("cont_range", range_sel_o, 3'b101);
            chk("cont_afe_sel", afe_sel_o, 0);
        end else begin
            chk("idle_after", busy_o, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int d;
        rst_i          = 1'b1;
        start_i        = 1'b0;
        cont_i         = 1'b0;
        range_i        = 3'b000;
        ref_ok_i       = 1'b1;
        comp_i         = 1'b0;
        sat_hi_i       = 1'b0;
        sat_lo_i       = 1'b0;
        result_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_outputs", {afe_sel_o, afe_reset_o, ref_sign_o,
            range_sel_o, busy_o, result_o, sign_o, err_o,
            result_valid_o}, 0);
        rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        chk("idle_after_reset", busy_o, 0);

        range_i = 3'b011;
        comp_i  = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        bad = 0;
        while (afe_sel_o != 2'b10 && bad < 60) begin
            @(posedge clk_i); #1;
            bad++;
        end
        chk("reached_int", afe_sel_o, 2'b10);
        #2 rst_i = 1'b1;
        #1;
        chk("async_reset_outputs", {afe_sel_o, afe_reset_o, ref_sign_o,
            range_sel_o, busy_o, result_o, sign_o, err_o,
            result_valid_o}, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk_i); #1;
            if (busy_o || afe_sel_o != 2'b00) bad++;
        end
        chk("stay_idle", bad, 0);

        conv(1'b1, 10, 1'b0, 0, 1'b0, 3'b010, 1'b1, 3, 1'b0);
        conv(1'b0, -1, 1'b0, 0, 1'b0, 3'b001, 1'b1, 2, 1'b0);
        conv(1'b1, -1, 1'b1, 5, 1'b0, 3'b111, 1'b1, 0, 1'b0);
        conv(1'b0, 38, 1'b0, 0, 1'b0, 3'b100, 1'b1, 1, 1'b0);
        conv(1'b1, 39, 1'b0, 0, 1'b0, 3'b110, 1'b1, 1, 1'b0);

        cont_i = 1'b1;
        conv(1'b0, 7, 1'b0, 0, 1'b0, 3'b011, 1'b1, 20, 1'b1);
        cont_i = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk_i); #1;
            if (!busy_o || afe_reset_o) bad++;
        end
        chk("ref_wait", bad, 0);
        ref_ok_i = 1'b1;
        @(posedge clk_i); #1;
        chk("ref_gate_c1", afe_reset_o, 0);
        @(posedge clk_i); #1;
        chk("ref_gate_c2", afe_reset_o, 0);
        @(posedge clk_i); #1;
        chk("ref_gate_c3", afe_reset_o, 1);
        conv(1'b1, 20, 1'b0, 0, 1'b0, 3'b101, 1'b0, 1, 1'b0);

        repeat (12) begin
            d = int'($urandom_range(46, 0)) - 1;
            conv(1'($urandom), d, ($urandom_range(3, 0) == 0),
                 int'($urandom_range(12, 0)), 1'($urandom),
                 3'($urandom), 1'b1, int'($urandom_range(4, 0)), 1'b0);
        end

        repeat (5) @(posedge clk_i);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
